ece178_pio_edge_capture_in: RTL and testbench
=============================================

// Module: ece178_pio_edge_capture_in
// PURPOSE
//  Avalon-MM slave input PIO: the read-side counterpart of the LED output PIOs, for KEY/SW pads.
//  Synchronizes and debounces in_port, latches selected edges and raises a maskable irq to the Nios II.
//  Register map: 0 data (RO), 1 direction (RO, reads 0), 2 irq mask (RW), 3 edge capture (RW1C).
// PARAMETERS
//  WIDTH           4   number of input bits (1..32)
//  SYNC_STAGES     2   synchronizer flops per bit (>=2)
//  DEBOUNCE_CYCLES 0   consecutive mismatching clk cycles before the stable bit flips; 0 = no filtering
//  EDGE_TYPE       1   0 rising, 1 falling, 2 any edge (applied to the stable bit)
// PORTS
//  clk         in   1      system clock
//  reset       in   1      asynchronous, active-high reset
//  address     in   2      register word offset
//  chipselect  in   1      slave select
//  write_n     in   1      active-low write strobe
//  writedata   in   32     write data; bits above WIDTH ignored
//  readdata    out  32     read data, zero-extended above WIDTH
//  in_port     in   WIDTH  asynchronous pad inputs
//  irq         out  1      level interrupt: |(edge_capture & irq_mask)
// BEHAVIOUR
//  - Reset: sync chain, stable, debounce counters, irq_mask, edge_capture, armed = 0. irq = 0, readdata = 0.
//  - Read: zero wait states; readdata is combinational from address (read latency 0). No read side effects.
//  - Write: chipselect && !write_n. Addr 2: irq_mask <= writedata[WIDTH-1:0].
//    Addr 3: edge_capture[i] cleared where writedata[i]=1. Addr 0/1: ignored.
//  - Sync: sync_out = last stage of a SYNC_STAGES flop chain on in_port.
//  - Debounce per bit: if sync_out != stable, cnt++; else cnt <= 0. stable flips when cnt == DEBOUNCE_CYCLES-1
//    and still mismatching (i.e. after DEBOUNCE_CYCLES consecutive mismatches). cnt clears on flip.
//    DEBOUNCE_CYCLES=0: stable <= sync_out every cycle. Counter width $clog2(DEBOUNCE_CYCLES+1), saturating.
//  - Data reg = stable. Latency pad change -> readdata: SYNC_STAGES + max(DEBOUNCE_CYCLES,1) edges.
//  - Arming: after reset, stable <= sync_out every cycle with no debounce and no edge detection until
//    SYNC_STAGES+1 cycles elapse; then armed = 1. This prevents false edges on idle-high keys.
//  - Edge capture: when armed, edge_capture[i] sets on the same clk edge that stable[i] changes in the
//    EDGE_TYPE direction. It holds until cleared by software.
//  - Simultaneous set and RW1C clear on the same bit in the same cycle: set wins.
//  - irq: combinational from registered edge_capture & irq_mask. It asserts in the cycle after capture
//    or after the mask write. Masking does not clear edge_capture.
//  - Pulses shorter than DEBOUNCE_CYCLES (after sync) are rejected and never captured.
//  - Reset mid-operation: all state returns to reset values immediately. Arming restarts.
// STRUCTURE
//  - Package ece178_pio_pkg: register offsets (PIO_ADDR_DATA/DIR/MASK/EDGE) and EDGE_RISING/FALLING/ANY.
//  - Sub-module ece178_pio_bit_filter (sync chain + debounce counter + stable bit, one per bit via generate).
//  - Top level: arming counter, edge detect, edge_capture/irq_mask regs, read mux, irq OR-reduce.
// TESTING  (WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, EDGE_TYPE=1 unless noted)
//  1. in_port=4'hF held through reset and arming -> data reads 4'hF, edge reg 0, irq 0 (no false edge).
//  2. in_port[2] 1->0 held 10 cycles -> data 4'hB after 2+4 edges; edge reg 4'h4; mask=4'h4 -> irq=1 next cycle.
//  3. 3-cycle low glitch on in_port[0] -> data stays 4'hF, edge reg stays 0, irq stays 0.
//  4. Edge reg=4'h5, write addr3 4'h1 -> reads 4'h4. Clear of bit 2 coincident with a new bit-2 edge -> bit 2 stays 1.
//  5. EDGE_TYPE=2, bit1 toggles 1->0->1 with clears between -> captured on both edges. Mask 0 -> irq 0, edge reg still set.
//  6. Assert reset mid-debounce (cnt=2) -> all regs 0, irq 0. After release, no capture until armed and debounced.

Source files
------------

// File: rtl/ece178_pio_edge_capture_in_pkg.sv
// Package: ece178_pio_pkg
// Purpose: shared constants for the edge-capture input PIO.
//   - Avalon register word offsets (data, direction, irq mask, edge capture).
//   - Edge-type selector values and a helper that decides whether a stable-bit
//     transition counts as a capturable edge.
package ece178_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_DIR  = 2'd1;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // True when the stable bit moving from prev to next matches edge_type.
  function automatic logic edge_hit(input logic prev, input logic next, input int edge_type);
    logic hit;
    case (edge_type)
      EDGE_RISING:  hit = ~prev & next;
      EDGE_FALLING: hit = prev & ~next;
      default:      hit = prev ^ next;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/ece178_pio_edge_capture_in_if.sv
// Interface: ece178_pio_edge_capture_in_if
// Purpose: Avalon-MM slave bus of the edge-capture input PIO, plus its irq line.
//   address    [1:0]  register word offset      (master -> slave)
//   chipselect        slave select              (master -> slave)
//   write_n           active-low write strobe   (master -> slave)
//   writedata  [31:0] write data                (master -> slave)
//   readdata   [31:0] combinational read data   (slave -> master)
//   irq               level interrupt           (slave -> master)
interface ece178_pio_edge_capture_in_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );

endinterface

// File: rtl/ece178_pio_edge_capture_in_bit_filter.sv
// Module: ece178_pio_bit_filter
// Purpose: one input bit's front end: SYNC_STAGES-deep synchronizer, then a
//   debounce counter that only lets the stable bit follow the synchronized
//   input after DEBOUNCE_CYCLES consecutive mismatching cycles.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   pad_in          raw asynchronous pad
//   bypass          1 = stable follows the synchronizer output every cycle
//   stable_o        registered stable bit
//   stable_next_o   value stable_o takes on the next clock edge
module ece178_pio_bit_filter #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic pad_in,
  input  logic bypass,
  output logic stable_o,
  output logic stable_next_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], pad_in};
    stable_d = stable_q;
    cnt_d    = '0;
    if (bypass || DEBOUNCE_CYCLES == 0) begin
      stable_d = sync_out;
    end else if (sync_out != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_out;           // counter clears on the flip
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o      = stable_q;
  assign stable_next_o = stable_d;

endmodule

// File: rtl/ece178_pio_edge_capture_in.sv
// Module: ece178_pio_edge_capture_in
// Purpose: Avalon-MM input PIO for KEY/SW pads. Synchronizes and debounces
//   in_port, latches selected edges into a RW1C edge-capture register and
//   raises a maskable level interrupt.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   bus          Avalon slave modport (address/chipselect/write_n/writedata/
//                readdata/irq)
//   in_port      asynchronous pad inputs, WIDTH bits
// Registers: 0 data (RO), 1 direction (RO, 0), 2 irq mask (RW),
//            3 edge capture (RW1C).
module ece178_pio_edge_capture_in
  import ece178_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = EDGE_FALLING
) (
  input  logic                         clk,
  input  logic                         reset,
  ece178_pio_edge_capture_in_if.slave  bus,
  input  logic [WIDTH-1:0]             in_port
);

  localparam int ARM_W = $clog2(SYNC_STAGES + 1);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES);

  logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
  logic             armed_q, armed_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] stable, stable_next;
  logic [WIDTH-1:0] edge_set, edge_clr;
  logic             wr_en;

  // Until armed, the filters pass the synchronizer straight through so the
  // stable bits settle to the idle pad levels without producing edges.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    ece178_pio_bit_filter #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_filter (
      .clk           (clk),
      .reset         (reset),
      .pad_in        (in_port[i]),
      .bypass        (~armed_q),
      .stable_o      (stable[i]),
      .stable_next_o (stable_next[i])
    );
  end

  assign wr_en = bus.chipselect && !bus.write_n;

  always_comb begin
    arm_cnt_d  = arm_cnt_q;
    armed_d    = armed_q;
    irq_mask_d = irq_mask_q;
    edge_set   = '0;
    edge_clr   = '0;

    // Arm after SYNC_STAGES+1 cycles: by then the stable bits hold real pad levels.
    if (!armed_q) begin
      if (arm_cnt_q == ARM_LAST) armed_d = 1'b1;
      else                       arm_cnt_d = arm_cnt_q + 1'b1;
    end

    // Edge seen on the same clock edge the stable bit changes.
    if (armed_q) begin
      for (int i = 0; i < WIDTH; i++) begin
        edge_set[i] = edge_hit(stable[i], stable_next[i], EDGE_TYPE);
      end
    end

    if (wr_en && bus.address == PIO_ADDR_MASK) irq_mask_d = bus.writedata[WIDTH-1:0];
    if (wr_en && bus.address == PIO_ADDR_EDGE) edge_clr   = bus.writedata[WIDTH-1:0];

    // A new edge beats a coincident software clear.
    edge_cap_d = (edge_cap_q & ~edge_clr) | edge_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arm_cnt_q  <= '0;
      armed_q    <= 1'b0;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
    end else begin
      arm_cnt_q  <= arm_cnt_d;
      armed_q    <= armed_d;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      PIO_ADDR_DATA: bus.readdata = 32'(stable);
      PIO_ADDR_MASK: bus.readdata = 32'(irq_mask_q);
      PIO_ADDR_EDGE: bus.readdata = 32'(edge_cap_q);
      default:       bus.readdata = '0;
    endcase
  end

  assign bus.irq = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_ece178_pio_edge_capture_in.sv
// Directed bench for ece178_pio_edge_capture_in: a falling-edge instance and an
// any-edge instance, both WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_ece178_pio_edge_capture_in;
  import ece178_pio_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_port_f;
  logic [3:0] in_port_a;
  int         total = 0;
  int         bad   = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  ece178_pio_edge_capture_in_if bus_f ();
  ece178_pio_edge_capture_in_if bus_a ();

  ece178_pio_edge_capture_in #(
    .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(EDGE_FALLING)
  ) dut_f (
    .clk(clk), .reset(reset), .bus(bus_f), .in_port(in_port_f)
  );

  ece178_pio_edge_capture_in #(
    .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(EDGE_ANY)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a), .in_port(in_port_a)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input int sel, input logic [1:0] addr, input logic [31:0] data);
    if (sel == 0) begin
      bus_f.address = addr; bus_f.writedata = data; bus_f.chipselect = 1'b1; bus_f.write_n = 1'b0;
    end else begin
      bus_a.address = addr; bus_a.writedata = data; bus_a.chipselect = 1'b1; bus_a.write_n = 1'b0;
    end
    tick();
    bus_f.chipselect = 1'b0; bus_f.write_n = 1'b1;
    bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1;
  endtask

  task automatic bus_read(input int sel, input logic [1:0] addr, output logic [31:0] data);
    if (sel == 0) begin
      bus_f.address = addr; bus_f.chipselect = 1'b1; #1; data = bus_f.readdata;
      bus_f.chipselect = 1'b0;
    end else begin
      bus_a.address = addr; bus_a.chipselect = 1'b1; #1; data = bus_a.readdata;
      bus_a.chipselect = 1'b0;
    end
  endtask

  initial begin
    bus_f.address = '0; bus_f.chipselect = 1'b0; bus_f.write_n = 1'b1; bus_f.writedata = '0;
    bus_a.address = '0; bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1; bus_a.writedata = '0;
    in_port_f = 4'hF;
    in_port_a = 4'hF;
    reset     = 1'b1;

    // 1: idle-high keys through reset and arming produce no edge
    tick(3);
    bus_read(0, PIO_ADDR_DATA, rd); check("reset_data", rd, 32'h0);
    check("reset_irq", {31'b0, bus_f.irq}, 32'h0);
    reset = 1'b0;
    tick(10);
    bus_read(0, PIO_ADDR_DATA, rd); check("t1_data", rd, 32'hF);
    bus_read(0, PIO_ADDR_EDGE, rd); check("t1_edge", rd, 32'h0);
    check("t1_irq", {31'b0, bus_f.irq}, 32'h0);
    bus_read(0, PIO_ADDR_DIR, rd);  check("t1_dir", rd, 32'h0);
    bus_read(1, PIO_ADDR_DATA, rd); check("t1_data_any", rd, 32'hF);

    // 2: bit 2 falls; stable flips on edge 6 (2 sync + 4 debounce)
    in_port_f = 4'hB;
    tick(5);
    bus_read(0, PIO_ADDR_DATA, rd); check("t2_data_edge5", rd, 32'hF);
    tick();
    bus_read(0, PIO_ADDR_DATA, rd); check("t2_data_edge6", rd, 32'hB);
    bus_read(0, PIO_ADDR_EDGE, rd); check("t2_edge", rd, 32'h4);
    check("t2_irq_unmasked", {31'b0, bus_f.irq}, 32'h0);
    bus_write(0, PIO_ADDR_MASK, 32'h4);
    check("t2_irq_masked", {31'b0, bus_f.irq}, 32'h1);
    bus_read(0, PIO_ADDR_MASK, rd); check("t2_mask", rd, 32'h4);
    in_port_f = 4'hF;                 // rising edge: not captured
    tick(8);
    bus_read(0, PIO_ADDR_EDGE, rd); check("t2_edge_after_rise", rd, 32'h4);
    bus_write(0, PIO_ADDR_EDGE, 32'hFFFF_FFFF);
    bus_read(0, PIO_ADDR_EDGE, rd); check("t2_edge_cleared", rd, 32'h0);
    check("t2_irq_cleared", {31'b0, bus_f.irq}, 32'h0);

    // 3: 3-cycle glitch is shorter than the debounce window
    in_port_f = 4'hE;
    tick(3);
    in_port_f = 4'hF;
    tick(10);
    bus_read(0, PIO_ADDR_DATA, rd); check("t3_data", rd, 32'hF);
    bus_read(0, PIO_ADDR_EDGE, rd); check("t3_edge", rd, 32'h0);
    check("t3_irq", {31'b0, bus_f.irq}, 32'h0);

    // 4: partial RW1C, then a clear coincident with a new edge on the same bit
    in_port_f = 4'hA;
    tick(6);
    bus_read(0, PIO_ADDR_EDGE, rd); check("t4_edge_5", rd, 32'h5);
    bus_write(0, PIO_ADDR_EDGE, 32'h1);
    bus_read(0, PIO_ADDR_EDGE, rd); check("t4_edge_after_clr1", rd, 32'h4);
    in_port_f = 4'hE;                 // bit 2 back high
    tick(8);
    in_port_f = 4'hA;                 // bit 2 falls again; flips on edge 6
    tick(5);
    bus_write(0, PIO_ADDR_EDGE, 32'h4); // write spans edge 6
    bus_read(0, PIO_ADDR_DATA, rd); check("t4_data", rd, 32'hA);
    bus_read(0, PIO_ADDR_EDGE, rd); check("t4_set_wins", rd, 32'h4);
    in_port_f = 4'hF;
    tick(8);
    check("t4_irq", {31'b0, bus_f.irq}, 32'h1);

    // 5: any-edge instance captures both directions; mask 0 keeps irq low
    in_port_a = 4'hD;
    tick(6);
    bus_read(1, PIO_ADDR_DATA, rd); check("t5_data_low", rd, 32'hD);
    bus_read(1, PIO_ADDR_EDGE, rd); check("t5_edge_fall", rd, 32'h2);
    bus_write(1, PIO_ADDR_EDGE, 32'h2);
    bus_read(1, PIO_ADDR_EDGE, rd); check("t5_edge_clr", rd, 32'h0);
    in_port_a = 4'hF;
    tick(5);
    bus_read(1, PIO_ADDR_EDGE, rd); check("t5_edge_rise_early", rd, 32'h0);
    tick();
    bus_read(1, PIO_ADDR_EDGE, rd); check("t5_edge_rise", rd, 32'h2);
    check("t5_irq_mask0", {31'b0, bus_a.irq}, 32'h0);

    // 6: reset while bit 3 is mid-debounce (cnt=2)
    bus_write(0, PIO_ADDR_MASK, 32'hF);
    in_port_f = 4'h7;
    tick(4);
    reset = 1'b1;
    #1;
    bus_read(0, PIO_ADDR_DATA, rd); check("t6_data_rst", rd, 32'h0);
    bus_read(0, PIO_ADDR_MASK, rd); check("t6_mask_rst", rd, 32'h0);
    bus_read(0, PIO_ADDR_EDGE, rd); check("t6_edge_rst", rd, 32'h0);
    check("t6_irq_rst", {31'b0, bus_f.irq}, 32'h0);
    tick(2);
    reset = 1'b0;
    tick(12);
    bus_read(0, PIO_ADDR_DATA, rd); check("t6_data_armed", rd, 32'h7);
    bus_read(0, PIO_ADDR_EDGE, rd); check("t6_edge_armed", rd, 32'h0);
    in_port_f = 4'hF;
    tick(8);
    in_port_f = 4'h7;
    tick(5);
    bus_read(0, PIO_ADDR_EDGE, rd); check("t6_edge_edge5", rd, 32'h0);
    tick();
    bus_read(0, PIO_ADDR_EDGE, rd); check("t6_edge_edge6", rd, 32'h8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
